projectile_ctl_dog: RTL and testbench

//  Trajectory controller for the dog's thrown projectile; direct upstream feeder of the dog projectile renderer.
//  On a fire request it launches a ballistic shot and advances it once per video frame.

---
 rtl/throw_pkg.sv | 34 +++
 rtl/vga_pkg.sv | 7 +
 rtl/throw_physics_step.sv | 40 ++++
 rtl/projectile_ctl_dog.sv | 140 ++++++++++++++
 tb/tb_projectile_ctl_dog.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/throw_pkg.sv
// Shared types and ballistic defaults for the thrown-projectile controllers.
// The cat-side controller is expected to reuse these defaults.
package throw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        DONE   = 2'd2
    } throw_state_t;

    // Signed 18-bit fixed point; the number of fractional bits is a parameter.
    typedef logic signed [17:0] fx18_t;

    localparam int DEF_FRAC         = 4;
    localparam int DEF_START_X      = 100;
    localparam int DEF_START_Y      = 150;
    localparam int DEF_GROUND_Y     = 40;
    localparam int DEF_VX_GAIN      = 2;
    localparam int DEF_VY_GAIN      = 3;
    localparam int DEF_GRAVITY      = 8;
    localparam int DEF_TARGET_X_MIN = 230;
    localparam int DEF_TARGET_X_MAX = 270;

    // Integer part to 12-bit screen coordinate, saturating at both ends.
    function automatic logic [11:0] clamp12(input fx18_t v);
        if (v[17])
            return 12'd0;
        else if (v > 18'sd4095)
            return 12'hfff;
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// Video timing constants shared by the sprite controllers and renderers.
package vga_pkg;

    localparam int HOR_PIXELS = 640;
    localparam int VER_PIXELS = 480;

endpackage

// File: rtl/throw_physics_step.sv
// One frame of ballistic motion: next x/y/vy plus the landing and exit tests
// evaluated on the new position. Purely combinational.
module throw_physics_step
    import throw_pkg::*;
#(
    parameter int FRAC         = DEF_FRAC,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int GROUND_Y     = DEF_GROUND_Y,
    parameter int TARGET_X_MIN = DEF_TARGET_X_MIN,
    parameter int TARGET_X_MAX = DEF_TARGET_X_MAX,
    parameter int X_LIMIT      = vga_pkg::HOR_PIXELS
) (
    input  fx18_t x,
    input  fx18_t y,
    input  fx18_t vx,
    input  fx18_t vy,
    input  fx18_t wind,
    output fx18_t x_nx,
    output fx18_t y_nx,
    output fx18_t vy_nx,
    output fx18_t x_int,
    output fx18_t y_int,
    output logic  off_screen,
    output logic  landed,
    output logic  on_target
);

    // Wind acts on position only; vx itself is constant for the whole flight.
    assign x_nx  = x + vx + wind;
    assign y_nx  = y + vy;
    assign vy_nx = vy - fx18_t'(GRAVITY);

    assign x_int = x_nx >>> FRAC;
    assign y_int = y_nx >>> FRAC;

    assign off_screen = x_int[17] || (x_int >= fx18_t'(X_LIMIT));
    assign landed     = (y_int <= fx18_t'(GROUND_Y));
    assign on_target  = (x_int >= fx18_t'(TARGET_X_MIN)) && (x_int <= fx18_t'(TARGET_X_MAX));

endmodule

// File: rtl/projectile_ctl_dog.sv
// Trajectory controller for the dog's projectile; feeds the dog projectile
// renderer with active/x_pos/y_pos and reports hit/miss on landing or exit.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for fire with non-zero power
//  FLIGHT | shot in the air, advanced once per frame_tick
//  DONE   | shot finished, hold off until the next frame_tick
module projectile_ctl_dog
    import throw_pkg::*;
#(
    parameter int FRAC         = DEF_FRAC,
    parameter int START_X      = DEF_START_X,
    parameter int START_Y      = DEF_START_Y,
    parameter int GROUND_Y     = DEF_GROUND_Y,
    parameter int VX_GAIN      = DEF_VX_GAIN,
    parameter int VY_GAIN      = DEF_VY_GAIN,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int TARGET_X_MIN = DEF_TARGET_X_MIN,
    parameter int TARGET_X_MAX = DEF_TARGET_X_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              fire,
    input  logic [6:0]        power,
    input  logic signed [5:0] wind,
    output logic              active,
    output logic [11:0]       x_pos,
    output logic [11:0]       y_pos,
    output logic              busy,
    output logic              hit,
    output logic              miss
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_FLIGHT = FLIGHT;
    localparam logic [1:0] ST_DONE   = DONE;

    localparam fx18_t X_LOAD = fx18_t'(START_X * (1 << FRAC));
    localparam fx18_t Y_LOAD = fx18_t'(START_Y * (1 << FRAC));

    logic [1:0] state;
    fx18_t      x, y, vx, vy, wind_r;
    fx18_t      x_nx, y_nx, vy_nx, x_int, y_int;
    logic       off_screen, landed, on_target;

    throw_physics_step #(
        .FRAC         (FRAC),
        .GRAVITY      (GRAVITY),
        .GROUND_Y     (GROUND_Y),
        .TARGET_X_MIN (TARGET_X_MIN),
        .TARGET_X_MAX (TARGET_X_MAX),
        .X_LIMIT      (vga_pkg::HOR_PIXELS)
    ) u_step (
        .x          (x),
        .y          (y),
        .vx         (vx),
        .vy         (vy),
        .wind       (wind_r),
        .x_nx       (x_nx),
        .y_nx       (y_nx),
        .vy_nx      (vy_nx),
        .x_int      (x_int),
        .y_int      (y_int),
        .off_screen (off_screen),
        .landed     (landed),
        .on_target  (on_target)
    );

    // Launch / per-frame advance / result reporting; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            x      <= '0;
            y      <= '0;
            vx     <= '0;
            vy     <= '0;
            wind_r <= '0;
            active <= 1'b0;
            x_pos  <= '0;
            y_pos  <= '0;
            busy   <= 1'b0;
            hit    <= 1'b0;
            miss   <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A coincident frame_tick does not move the shot: it starts next frame.
                    if (fire && (power != 7'd0)) begin
                        x      <= X_LOAD;
                        y      <= Y_LOAD;
                        vx     <= fx18_t'(int'(power) * VX_GAIN);
                        vy     <= fx18_t'(int'(power) * VY_GAIN);
                        wind_r <= fx18_t'(wind);
                        active <= 1'b1;
                        busy   <= 1'b1;
                        x_pos  <= clamp12(fx18_t'(START_X));
                        y_pos  <= clamp12(fx18_t'(START_Y));
                        state  <= ST_FLIGHT;
                    end
                end
                ST_FLIGHT: begin
                    if (frame_tick) begin
                        x     <= x_nx;
                        y     <= y_nx;
                        vy    <= vy_nx;
                        x_pos <= clamp12(x_int);
                        y_pos <= clamp12(y_int);
                        // Leaving the screen wins over a same-frame landing.
                        if (off_screen) begin
                            miss   <= 1'b1;
                            active <= 1'b0;
                            state  <= ST_DONE;
                        end else if (landed) begin
                            hit    <= on_target;
                            miss   <= !on_target;
                            active <= 1'b0;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_tick) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_projectile_ctl_dog.sv
// Bench for projectile_ctl_dog: closed-form trajectory model feeding a
// per-cycle scoreboard, a table of shots with hand-derived landing results,
// and short sequences for reset, ignored fire and held fire.
module tb_projectile_ctl_dog;

    logic              clk;
    logic              rst;
    logic              frame_tick;
    logic              fire;
    logic [6:0]        power;
    logic signed [5:0] wind;
    logic              active;
    logic [11:0]       x_pos;
    logic [11:0]       y_pos;
    logic              busy;
    logic              hit;
    logic              miss;

    projectile_ctl_dog dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .fire       (fire),
        .power      (power),
        .wind       (wind),
        .active     (active),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .busy       (busy),
        .hit        (hit),
        .miss       (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        active;
        logic [11:0] x_pos;
        logic [11:0] y_pos;
        logic        busy;
        logic        hit;
        logic        miss;
    } obs_t;

    typedef struct {
        int p;
        int w;
        bit hold;
        int tick;
        int x;
        int y;
        bit is_hit;
    } vec_t;

    obs_t  sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_tag = "reset";

    // Reference model state (closed-form ballistic position after n frames).
    int   m_state = 0;
    int   m_n = 0, m_vx = 0, m_vy0 = 0, m_w = 0;
    obs_t m_out = '0;

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    task automatic model_cycle(input logic r, input logic f, input logic ft, input int p, input int w);
        int xf, yf, xi, yi;
        m_out.hit  = 1'b0;
        m_out.miss = 1'b0;
        if (r) begin
            m_state = 0;
            m_out   = '0;
            m_n     = 0;
        end else begin
            case (m_state)
                0: if (f && p != 0) begin
                    m_vx = 2 * p; m_vy0 = 3 * p; m_w = w; m_n = 0;
                    m_state = 1;
                    m_out.active = 1'b1; m_out.busy = 1'b1;
                    m_out.x_pos = 12'd100; m_out.y_pos = 12'd150;
                end
                1: if (ft) begin
                    m_n++;
                    xf = 1600 + m_n * (m_vx + m_w);
                    yf = 2400 + m_n * m_vy0 - (8 * m_n * (m_n - 1)) / 2;
                    xi = xf >>> 4;
                    yi = yf >>> 4;
                    m_out.x_pos = 12'(clampi(xi));
                    m_out.y_pos = 12'(clampi(yi));
                    if (xi >= 640 || xi < 0) begin
                        m_out.miss = 1'b1; m_out.active = 1'b0; m_state = 2;
                    end else if (yi <= 40) begin
                        if (xi >= 230 && xi <= 270) m_out.hit = 1'b1;
                        else m_out.miss = 1'b1;
                        m_out.active = 1'b0; m_state = 2;
                    end
                end
                default: if (ft) begin
                    m_state = 0; m_out.busy = 1'b0;
                end
            endcase
        end
        sb_q.push_back(m_out);
    endtask

    task automatic check_out();
        obs_t a, e;
        a = {active, x_pos, y_pos, busy, hit, miss};
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got x=%0d y=%0d", cur_tag, a.x_pos, a.y_pos);
            return;
        end
        e = sb_q.pop_front();
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got act=%0b x=%0d y=%0d busy=%0b hit=%0b miss=%0b, want act=%0b x=%0d y=%0d busy=%0b hit=%0b miss=%0b",
                     cur_tag, $time, a.active, a.x_pos, a.y_pos, a.busy, a.hit, a.miss,
                     e.active, e.x_pos, e.y_pos, e.busy, e.hit, e.miss);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, want %0d", cur_tag, name, act, exp);
        end
    endtask

    // Drive one clock cycle of inputs, then compare the registered result.
    task automatic cycle(input logic r, input logic f, input logic ft, input int p, input int w);
        rst = r; fire = f; frame_tick = ft;
        power = 7'(p); wind = 6'(w);
        model_cycle(r, f, ft, p, w);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    // Launch, then tick every other cycle until hit/miss or the frame budget expires.
    task automatic run_shot(input int p, input int w, input logic hold,
                            output int land_tick, output int lx, output int ly,
                            output int got_hit, output int got_miss);
        land_tick = -1; lx = -1; ly = -1; got_hit = 0; got_miss = 0;
        cycle(1'b0, 1'b1, 1'b0, p, w);
        for (int t = 1; t <= 200 && land_tick < 0; t++) begin
            cycle(1'b0, hold, 1'b1, p, w);
            if (hit || miss) begin
                land_tick = t; lx = x_pos; ly = y_pos;
                got_hit = hit; got_miss = miss;
            end
            cycle(1'b0, hold, 1'b0, p, w);
        end
        if (land_tick < 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s/timeout: no hit or miss within 200 frames", cur_tag);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int lt, lx, ly, gh, gm;

        vecs[0] = '{p: 32,  w: 0,   hold: 1'b0, tick: 37, x: 248, y: 39,  is_hit: 1'b1};
        vecs[1] = '{p: 32,  w: -16, hold: 1'b0, tick: 37, x: 211, y: 39,  is_hit: 1'b0};
        vecs[2] = '{p: 127, w: 31,  hold: 1'b0, tick: 31, x: 652, y: 655, is_hit: 1'b0};
        vecs[3] = '{p: 32,  w: 0,   hold: 1'b1, tick: 37, x: 248, y: 39,  is_hit: 1'b1};
        vecs[4] = '{p: 1,   w: 0,   hold: 1'b0, tick: 22, x: 102, y: 38,  is_hit: 1'b0};
        vecs[5] = '{p: 32,  w: -8,  hold: 1'b0, tick: 37, x: 229, y: 39,  is_hit: 1'b0};
        vecs[6] = '{p: 32,  w: -7,  hold: 1'b0, tick: 37, x: 231, y: 39,  is_hit: 1'b1};
        vecs[7] = '{p: 32,  w: 10,  hold: 1'b0, tick: 37, x: 271, y: 39,  is_hit: 1'b0};

        rst = 1'b1; fire = 1'b0; frame_tick = 1'b0; power = '0; wind = '0;

        cur_tag = "reset";
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 1'b1, 32, 0);
        chk("active", active, 0);
        chk("x_pos", x_pos, 0);
        chk("busy", busy, 0);

        // fire with power 0 in IDLE, also with a coincident tick
        cur_tag = "power0";
        cycle(1'b0, 1'b1, 1'b0, 0, 5);
        cycle(1'b0, 1'b1, 1'b1, 0, 5);
        cycle(1'b0, 1'b1, 1'b0, 0, 5);
        chk("active", active, 0);
        chk("busy", busy, 0);

        // fire and frame_tick together: launch only, no motion yet
        cur_tag = "fire_tick";
        cycle(1'b0, 1'b1, 1'b1, 32, 0);
        chk("x_pos", x_pos, 100);
        chk("y_pos", y_pos, 150);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);

        foreach (vecs[i]) begin
            cur_tag = $sformatf("vec%0d", i);
            run_shot(vecs[i].p, vecs[i].w, vecs[i].hold, lt, lx, ly, gh, gm);
            chk("land_tick", lt, vecs[i].tick);
            chk("land_x", lx, vecs[i].x);
            chk("land_y", ly, vecs[i].y);
            chk("hit", gh, int'(vecs[i].is_hit));
            chk("miss", gm, int'(!vecs[i].is_hit));
            chk("active_done", active, 0);
            chk("busy_done", busy, 1);
            cycle(1'b0, 1'b0, 1'b1, 0, 0);
            chk("busy_idle", busy, 0);
            cycle(1'b0, 1'b0, 1'b0, 0, 0);
        end

        // reset on the 10th frame, then relaunch from the start point
        cur_tag = "midrst";
        cycle(1'b0, 1'b1, 1'b0, 32, 0);
        for (int t = 1; t <= 9; t++) begin
            cycle(1'b0, 1'b0, 1'b1, 32, 0);
            cycle(1'b0, 1'b0, 1'b0, 32, 0);
        end
        chk("x_before", x_pos, 136);
        cycle(1'b1, 1'b0, 1'b1, 32, 0);
        chk("active", active, 0);
        chk("x_pos", x_pos, 0);
        chk("y_pos", y_pos, 0);
        chk("busy", busy, 0);
        chk("hitmiss", int'(hit) + int'(miss), 0);
        cycle(1'b0, 1'b0, 1'b1, 32, 0);
        chk("still_idle", busy, 0);
        cycle(1'b0, 1'b1, 1'b0, 32, 0);
        chk("relaunch_x", x_pos, 100);
        chk("relaunch_y", y_pos, 150);
        chk("relaunch_act", active, 1);
        cycle(1'b0, 1'b0, 1'b1, 32, 0);
        chk("tick1_x", x_pos, 104);
        chk("tick1_y", y_pos, 156);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);

        // fire held through a whole shot: DONE holds until the next tick, then relaunch
        cur_tag = "held";
        run_shot(32, 0, 1'b1, lt, lx, ly, gh, gm);
        chk("land_tick", lt, 37);
        chk("hit", gh, 1);
        cycle(1'b0, 1'b1, 1'b0, 32, 0);
        cycle(1'b0, 1'b1, 1'b0, 32, 0);
        chk("done_busy", busy, 1);
        chk("done_active", active, 0);
        chk("done_x_hold", x_pos, 248);
        cycle(1'b0, 1'b1, 1'b1, 32, 0);
        chk("idle_busy", busy, 0);
        chk("idle_active", active, 0);
        cycle(1'b0, 1'b1, 1'b0, 32, 0);
        chk("relaunch_act", active, 1);
        chk("relaunch_x", x_pos, 100);
        chk("relaunch_busy", busy, 1);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);

        if (sb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard: %0d entries left over, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
